// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel edge stage: pipeline depth and widths derived from the pixel width.
package sobel_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int CNT_WIDTH_DEF  = 19;
  localparam int SOBEL_LATENCY  = 3;

  localparam int GRAD_W  = DATA_WIDTH_DEF + 2;
  localparam int SUM_W   = DATA_WIDTH_DEF + 3;
  localparam int MAG_MAX = (1 << DATA_WIDTH_DEF) - 1;

  // Width helpers so instances with a non-default pixel width stay consistent.
  function automatic int grad_w(input int dw);
    return dw + 2;
  endfunction

  function automatic int sum_w(input int dw);
    return dw + 3;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register that keeps frame/line syncs aligned with a filter pipeline.
// Exposes the last stage and the one before it so the filter can gate its final data register.
module sync_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_pre
);

  logic [DEPTH*WIDTH-1:0] shift_q;
  logic [DEPTH*WIDTH-1:0] shift_d;

  // Stage 0 occupies the low slice; DEPTH must be at least 2.
  always_comb begin
    shift_d = {shift_q[(DEPTH-1)*WIDTH-1:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign dout     = shift_q[(DEPTH-1)*WIDTH +: WIDTH];
  assign dout_pre = shift_q[(DEPTH-2)*WIDTH +: WIDTH];

endmodule

// File: rtl/sobel_edge_detector.sv
// Sobel |Gx|+|Gy| on a 3x3 window in a 3-stage pipeline, with saturated magnitude, threshold edge bit
// and a per-frame edge-pixel counter. Accepts one window per clock, never stalls.
module sobel_edge_detector
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  matrix_frame_vsync,
  input  logic                  matrix_frame_href,
  input  logic [DATA_WIDTH-1:0] matrix_p11,
  input  logic [DATA_WIDTH-1:0] matrix_p12,
  input  logic [DATA_WIDTH-1:0] matrix_p13,
  input  logic [DATA_WIDTH-1:0] matrix_p21,
  input  logic [DATA_WIDTH-1:0] matrix_p22,
  input  logic [DATA_WIDTH-1:0] matrix_p23,
  input  logic [DATA_WIDTH-1:0] matrix_p31,
  input  logic [DATA_WIDTH-1:0] matrix_p32,
  input  logic [DATA_WIDTH-1:0] matrix_p33,
  input  logic [DATA_WIDTH-1:0] threshold,
  output logic                  post_frame_vsync,
  output logic                  post_frame_href,
  output logic [DATA_WIDTH-1:0] post_img_mag,
  output logic                  post_img_edge,
  output logic [CNT_WIDTH-1:0]  frame_edge_cnt,
  output logic                  frame_done
);

  localparam int GW = grad_w(DATA_WIDTH);
  localparam int SW = sum_w(DATA_WIDTH);
  localparam logic [SW-1:0] MAG_SAT = {{(SW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

  logic [1:0] sync_out;
  logic [1:0] sync_pre;

  sync_delay_line #(
    .WIDTH (2),
    .DEPTH (SOBEL_LATENCY)
  ) u_sync_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      ({matrix_frame_vsync, matrix_frame_href}),
    .dout     (sync_out),
    .dout_pre (sync_pre)
  );

  assign post_frame_vsync = sync_out[1];
  assign post_frame_href  = sync_out[0];

  // Stage 1: weighted column/row sums, kept unsigned.
  logic [GW-1:0] gx_p_q, gx_n_q, gy_p_q, gy_n_q;
  logic [GW-1:0] gx_p_d, gx_n_d, gy_p_d, gy_n_d;

  always_comb begin
    gx_p_d = GW'(matrix_p13) + (GW'(matrix_p23) << 1) + GW'(matrix_p33);
    gx_n_d = GW'(matrix_p11) + (GW'(matrix_p21) << 1) + GW'(matrix_p31);
    gy_p_d = GW'(matrix_p11) + (GW'(matrix_p12) << 1) + GW'(matrix_p13);
    gy_n_d = GW'(matrix_p31) + (GW'(matrix_p32) << 1) + GW'(matrix_p33);
  end

  // Stage 2: absolute differences as larger minus smaller.
  logic [GW-1:0] abs_gx_q, abs_gy_q;
  logic [GW-1:0] abs_gx_d, abs_gy_d;

  always_comb begin
    abs_gx_d = (gx_p_q >= gx_n_q) ? (gx_p_q - gx_n_q) : (gx_n_q - gx_p_q);
    abs_gy_d = (gy_p_q >= gy_n_q) ? (gy_p_q - gy_n_q) : (gy_n_q - gy_p_q);
  end

  // Stage 3: gated by the href that lands in the last sync stage on the same edge.
  logic [SW-1:0]         sum;
  logic [DATA_WIDTH-1:0] mag_q, mag_d;
  logic                  edge_q, edge_d;

  always_comb begin
    sum    = SW'(abs_gx_q) + SW'(abs_gy_q);
    mag_d  = '0;
    edge_d = 1'b0;
    if (sync_pre[0]) begin
      mag_d  = (sum > MAG_SAT) ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
      edge_d = (sum > SW'(threshold));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_p_q   <= '0;
      gx_n_q   <= '0;
      gy_p_q   <= '0;
      gy_n_q   <= '0;
      abs_gx_q <= '0;
      abs_gy_q <= '0;
      mag_q    <= '0;
      edge_q   <= 1'b0;
    end else begin
      gx_p_q   <= gx_p_d;
      gx_n_q   <= gx_n_d;
      gy_p_q   <= gy_p_d;
      gy_n_q   <= gy_n_d;
      abs_gx_q <= abs_gx_d;
      abs_gy_q <= abs_gy_d;
      mag_q    <= mag_d;
      edge_q   <= edge_d;
    end
  end

  assign post_img_mag  = mag_q;
  assign post_img_edge = edge_q;

  // Per-frame edge accounting on the delayed syncs.
  logic                 vs_prev_q;
  logic [CNT_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] frame_edge_cnt_q, frame_edge_cnt_d;
  logic                 frame_done_q, frame_done_d;
  logic                 inc;
  logic [CNT_WIDTH-1:0] acc_inc;
  logic                 vs_fall;
  logic                 vs_rise;

  always_comb begin
    inc              = post_frame_href & edge_q;
    acc_inc          = (inc && (acc_q != {CNT_WIDTH{1'b1}})) ? (acc_q + CNT_WIDTH'(1)) : acc_q;
    vs_fall          = vs_prev_q & ~post_frame_vsync;
    vs_rise          = ~vs_prev_q & post_frame_vsync;
    acc_d            = acc_inc;
    frame_edge_cnt_d = frame_edge_cnt_q;
    frame_done_d     = 1'b0;
    if (vs_fall) begin
      frame_edge_cnt_d = acc_inc;
      frame_done_d     = 1'b1;
      acc_d            = '0;
    end else if (vs_rise) begin
      // Stale partial counts are dropped; a pixel arriving with the rising edge belongs to the new frame.
      acc_d = CNT_WIDTH'(inc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_q        <= 1'b0;
      acc_q            <= '0;
      frame_edge_cnt_q <= '0;
      frame_done_q     <= 1'b0;
    end else begin
      vs_prev_q        <= post_frame_vsync;
      acc_q            <= acc_d;
      frame_edge_cnt_q <= frame_edge_cnt_d;
      frame_done_q     <= frame_done_d;
    end
  end

  assign frame_edge_cnt = frame_edge_cnt_q;
  assign frame_done     = frame_done_q;

endmodule
